// File: rtl/bs_rr_rbtr_bp.sv
// Bus arbiter: grants one pending driver (round-robin or fixed priority), pops its head packet,
// then pushes it to its unicast or broadcast receivers, waiting on backpressure up to TMOUT cycles.
module bs_rr_rbtr_bp #(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 32,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         MODE      = 0,
  parameter int         TMOUT     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int         WW     = (TMOUT > 1) ? $clog2(TMOUT) : 1;
  localparam logic [WW-1:0] TM1 = WW'(TMOUT - 1);
  localparam logic [7:0] DRVRS8 = 8'(DRVRS);

  typedef enum logic [1:0] {IDLE, POP, DLVR} state_t;

  state_t               state_q, state_d;
  logic [7:0]           grant_q, grant_d;
  logic [7:0]           last_q, last_d;
  logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [15:0]          drop_q, drop_d;

  logic [7:0]           win;
  logic                 found;
  int                   idx;
  logic [7:0]           tgt, src;
  logic                 is_uni, is_bc, rdy;
  logic [DRVRS-1:0]     dest;

  // Winner search; MODE 0 starts just after the last grant and wraps.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < DRVRS; k++) begin
      if (MODE == 1) idx = k;
      else           idx = (int'(last_q) + 1 + k) % DRVRS;
      for (int j = 0; j < DRVRS; j++) begin
        if (j == idx && pndng[j] && !found) begin
          win   = 8'(j);
          found = 1'b1;
        end
      end
    end
  end

  assign tgt    = pkt_q[PCKG_SZ-1 -: 8];
  assign src    = pkt_q[PCKG_SZ-9 -: 8];
  assign is_uni = (tgt < DRVRS8);
  assign is_bc  = !is_uni && (tgt == BROADCAST);

  // Broadcast skips the source only when the source is a real index.
  always_comb begin
    dest = '0;
    for (int i = 0; i < DRVRS; i++) begin
      if (is_uni)     dest[i] = (tgt == 8'(i));
      else if (is_bc) dest[i] = !((src < DRVRS8) && (src == 8'(i)));
    end
  end

  assign rdy = (is_uni || is_bc) && ((dest & full) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= DRVRS8 - 8'd1;
      pkt_q   <= '0;
      wait_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    wait_d  = wait_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (pndng != '0) begin
          state_d = POP;
          grant_d = win;
          last_d  = win;
        end
      end
      POP: begin
        for (int j = 0; j < DRVRS; j++) begin
          if (8'(j) == grant_q) pkt_d = D_pop[j*PCKG_SZ +: PCKG_SZ];
        end
        wait_d  = '0;
        state_d = DLVR;
      end
      DLVR: begin
        if (rdy) begin
          state_d = IDLE;
        end else if (!(is_uni || is_bc) || wait_q == TM1) begin
          state_d = IDLE;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = '0;
    push = '0;
    busy = (state_q != IDLE);
    for (int j = 0; j < DRVRS; j++) begin
      pop[j] = (state_q == POP) && (8'(j) == grant_q);
    end
    if (state_q == DLVR && rdy) push = dest;
  end

  assign D_push   = {DRVRS{pkt_q}};
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bs_rr_rbtr_bp.sv
// Directed bench: round-robin instance and fixed-priority instance share stimulus.
module tb_bs_rr_rbtr_bp;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     pndng, full;
  logic [N*W-1:0]   D_pop;
  logic [N-1:0]     pop_r, push_r, pop_f, push_f;
  logic [N*W-1:0]   dpush_r, dpush_f;
  logic             busy_r, busy_f;
  logic [15:0]      drop_r, drop_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bs_rr_rbtr_bp #(.DRVRS(N), .PCKG_SZ(W), .BROADCAST(8'hFF), .MODE(0), .TMOUT(16)) u_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
    .pop(pop_r), .push(push_r), .D_push(dpush_r), .busy(busy_r), .drop_cnt(drop_r));

  bs_rr_rbtr_bp #(.DRVRS(N), .PCKG_SZ(W), .BROADCAST(8'hFF), .MODE(1), .TMOUT(16)) u_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
    .pop(pop_f), .push(push_f), .D_push(dpush_f), .busy(busy_f), .drop_cnt(drop_f));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] t, input logic [7:0] s, input logic [15:0] p);
    return {t, s, p};
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] v);
    D_pop[i*W +: W] = v;
  endtask

  logic [W-1:0] pkt;
  logic [N-1:0] expv;

  initial begin
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    D_pop = '0;
    #2;
    chk("rst_busy", busy_r, 1'b0);
    chk("rst_pop", pop_r, 4'b0);
    chk("rst_push", push_r, 4'b0);
    chk("rst_drop", drop_r, 16'd0);
    chk("rst_dpush", dpush_r, 128'd0);
    #10;
    reset = 1'b0;
    tick();

    // Ring traffic, round-robin grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_lane(i, mk(8'((i + 1) % N), 8'(i), 16'hA0 + 16'(i)));
    pndng = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      expv = 4'(1 << (k % N));
      chk("rr_pop", pop_r, expv);
      tick();
      expv = 4'(1 << ((k + 1) % N));
      chk("rr_push", push_r, expv);
      chk("rr_data", dpush_r[W-1:0], mk(8'((k + 1) % N), 8'(k % N), 16'hA0 + 16'(k % N)));
      if (k == 4) pndng = '0;
      tick();
      chk("rr_idle", busy_r, 1'b0);
    end
    tick();

    // Fixed priority with 1010 held: driver 1 always.
    set_lane(1, mk(8'd0, 8'd1, 16'h1111));
    set_lane(3, mk(8'd0, 8'd3, 16'h3333));
    pndng = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fp_pop", pop_f, 4'b0010);
      tick();
      chk("fp_push", push_f, 4'b0001);
      chk("fp_data", dpush_f[W-1:0], mk(8'd0, 8'd1, 16'h1111));
      if (k == 3) pndng = '0;
      tick();
      chk("fp_idle", busy_f, 1'b0);
    end

    // Broadcast from driver 2.
    pkt = mk(8'hFF, 8'd2, 16'hBC02);
    set_lane(2, pkt);
    pndng = 4'b0100;
    tick();
    chk("bc_pop", pop_r, 4'b0100);
    tick();
    chk("bc_push", push_r, 4'b1011);
    chk("bc_lanes", dpush_r, {N{pkt}});
    pndng = '0;
    tick();
    chk("bc_idle", busy_r, 1'b0);

    // Backpressure released before the 6th DLVR cycle.
    pkt = mk(8'd1, 8'd0, 16'h5A5A);
    set_lane(0, pkt);
    full  = 4'b0010;
    pndng = 4'b0001;
    tick();
    chk("bp_pop", pop_r, 4'b0001);
    pndng = '0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("bp_wait_push", push_r, 4'b0);
      chk("bp_wait_busy", busy_r, 1'b1);
    end
    tick();
    full = 4'b0000;
    #1;
    chk("bp_push", push_r, 4'b0010);
    chk("bp_data", dpush_r[2*W-1:W], pkt);
    tick();
    chk("bp_idle", busy_r, 1'b0);
    chk("bp_drop", drop_r, 16'd0);

    // Timeout after 16 DLVR cycles.
    full  = 4'b0010;
    pndng = 4'b0001;
    tick();
    pndng = '0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to_push", push_r, 4'b0);
    end
    chk("to_drop_pre", drop_r, 16'd0);
    chk("to_busy_pre", busy_r, 1'b1);
    tick();
    chk("to_drop", drop_r, 16'd1);
    chk("to_idle", busy_r, 1'b0);

    // Invalid target dropped in the first DLVR cycle.
    full = '0;
    set_lane(0, mk(8'h07, 8'd0, 16'hDEAD));
    pndng = 4'b0001;
    tick();
    pndng = '0;
    tick();
    chk("inv_push", push_r, 4'b0);
    chk("inv_busy", busy_r, 1'b1);
    tick();
    chk("inv_idle", busy_r, 1'b0);
    chk("inv_drop", drop_r, 16'd2);

    // Reset asserted while stalled in DLVR.
    set_lane(0, mk(8'd1, 8'd0, 16'h7777));
    full  = 4'b0010;
    pndng = 4'b0001;
    tick();
    pndng = '0;
    tick();
    chk("mid_busy", busy_r, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_r, 1'b0);
    chk("mid_rst_push", push_r, 4'b0);
    chk("mid_rst_pop", pop_r, 4'b0);
    chk("mid_rst_drop", drop_r, 16'd0);
    chk("mid_rst_dpush", dpush_r, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    full  = '0;
    for (int i = 0; i < N; i++) set_lane(i, mk(8'((i + 1) % N), 8'(i), 16'hC0 + 16'(i)));
    pndng = 4'hF;
    tick();
    chk("post_rst_grant", pop_r, 4'b0001);
    pndng = '0;
    tick();
    chk("post_rst_push", push_r, 4'b0010);
    tick();
    tick();
    chk("post_rst_drop", drop_r, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
